ps2_rx_fifo: RTL and testbench

Receive-only PS/2 front end between the board's PS/2 lines and the system core. The keyboard lines come from the ESP32 bridge and the mouse lines from the USB D+/D- pins. The block synchronises and deglitches the clock and data lines, deframes 11-bit PS/2 frames and checks start, parity and stop bits. Good bytes are buffered in a show-ahead FIFO, and sticky error flags are exposed. One instance is used per port (keyboard, mouse).

---
 rtl/ps2_rx_fifo_pkg.sv | 22 ++
 rtl/ps2_rx_fifo_if.sv | 25 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 53 +++++
 rtl/ps2_rx_fifo.sv | 160 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path: FSM state encoding,
// frame geometry and the timeout count helper.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // Number of clk cycles in timeout_us microseconds.
  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Core-side bus of the PS/2 receiver: FIFO read port and sticky status.
// master = system core, slave = ps2_rx_fifo.
`timescale 1ns/1ps
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic [FIFO_AW:0]   fifo_count;
  logic               err_parity;
  logic               err_frame;
  logic               overrun;
  logic               clr_err;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, fifo_count, err_parity, err_frame, overrun
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, fifo_count, err_parity, err_frame, overrun
  );
endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is always visible on rd_data
// (zero when empty). A push into a full FIFO is accepted only if a pop
// happens in the same cycle; otherwise it is dropped and flagged on overflow.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          overflow
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full     = (count == DEPTH);
  assign rd_valid = (count != '0);
  assign do_pop   = pop & rd_valid;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage array; contents beyond count are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; count tracks occupancy separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front end: synchroniser, clock deglitch filter, frame FSM,
// byte FIFO and sticky error flags.
// Optional build macro PS2_RX_TIMEOUT_EN adds an inter-edge timeout that
// aborts a stalled frame and flags it as a frame error.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a start bit (data low on a fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | next fall carries the odd-parity bit
// ST_STOP   | next fall carries the stop bit; check and push
`timescale 1ns/1ps
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int FIFO_AW    = 4,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_fifo_if.slave bus
);
  localparam int TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);

  logic [1:0]            sync_clk, sync_data;
  logic                  clk_s, data_s;
  logic [FILTER_LEN-1:0] filt_sh;
  logic                  filt_clk, fall;

  ps2_state_t            state;
  logic [2:0]            bitcnt;
  logic [7:0]            shreg;
  logic                  par_bit;
  logic                  err_parity, err_frame, overrun;
  logic                  stop_fall, par_ok, push, set_par, set_frm;
  logic                  fifo_ovf, timeout_hit;

  assign clk_s  = sync_clk[1];
  assign data_s = sync_data[1];

  // Two-flop synchronisers; idle lines are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_clk  <= 2'b11;
      sync_data <= 2'b11;
    end else begin
      sync_clk  <= {sync_clk[0], ps2_clk};
      sync_data <= {sync_data[0], ps2_data};
    end
  end

  // Clock deglitch: filtered level flips only on a full window of agreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_sh  <= '1;
      filt_clk <= 1'b1;
    end else begin
      filt_sh <= {filt_sh[FILTER_LEN-2:0], clk_s};
      if (&filt_sh)       filt_clk <= 1'b1;
      else if (~|filt_sh) filt_clk <= 1'b0;
    end
  end

  // One-cycle strobe in the cycle the window first reads all-low.
  assign fall = filt_clk & ~|filt_sh;

  assign stop_fall = fall && (state == ST_STOP);
  assign par_ok    = ^{shreg, par_bit};
  assign push      = stop_fall & par_ok & data_s;
  assign set_par   = stop_fall & ~par_ok;
  assign set_frm   = (stop_fall & ~data_s) | timeout_hit;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Down-counter reloaded on every fall and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             to_cnt <= TW'(TIMEOUT_CYC);
    else if (fall || state == ST_IDLE)   to_cnt <= TW'(TIMEOUT_CYC);
    else if (to_cnt != '0)               to_cnt <= to_cnt - 1'b1;
  end

  assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TW'(1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
`endif

  // Frame FSM plus the sticky parity/frame flags; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      if (set_par)          err_parity <= 1'b1;
      else if (bus.clr_err) err_parity <= 1'b0;
      if (set_frm)          err_frame  <= 1'b1;
      else if (bus.clr_err) err_frame  <= 1'b0;

      if (timeout_hit) begin
        state  <= ST_IDLE;
        bitcnt <= '0;
        shreg  <= '0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg <= {data_s, shreg[7:1]};
            if (bitcnt == 3'(PS2_DATA_BITS - 1)) state  <= ST_PARITY;
            else                                 bitcnt <= bitcnt + 3'd1;
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          ST_STOP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky overrun: a good byte arrived with no room for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (fifo_ovf)    overrun <= 1'b1;
    else if (bus.clr_err) overrun <= 1'b0;
  end

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_data  (shreg),
    .pop      (bus.rd_en),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .count    (bus.fifo_count),
    .overflow (fifo_ovf)
  );

  assign bus.err_parity = err_parity;
  assign bus.err_frame  = err_frame;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, parity/stop errors, overrun,
// simultaneous push/pop, glitch rejection, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  int   half = 20;
  int   checks = 0;
  int   errors = 0;

  ps2_rx_fifo_if #(.FIFO_AW(4)) bus ();

  ps2_rx_fifo #(
    .CLK_HZ(25000000), .FIFO_AW(4), .FILTER_LEN(8), .TIMEOUT_US(200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // One PS/2 bit: data set while clock high, then a low phase. Optionally a
  // short high glitch in the low phase, or rd_en/clr_err in the fall cycle.
  task automatic ps2_bit(input logic b, input bit glitch, input bit do_pop, input bit do_clr);
    @(negedge clk); ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    if (do_pop || do_clr) begin
      repeat (10) @(posedge clk);
      @(negedge clk); bus.rd_en = do_pop; bus.clr_err = do_clr;
      @(negedge clk); bus.rd_en = 1'b0;   bus.clr_err = 1'b0;
      repeat (half) @(negedge clk);
    end else if (glitch) begin
      repeat (12) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int glitch_bit, input bit pop_stop, input bit clr_stop);
    ps2_bit(1'b0, glitch_bit == 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch_bit == i + 1, 1'b0, 1'b0);
    ps2_bit(par, 1'b0, 1'b0, 1'b0);
    ps2_bit(stp, 1'b0, pop_stop, clr_stop);
    repeat (4) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1, -1, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    @(negedge clk); bus.rd_en = 1'b1;
    @(negedge clk); bus.rd_en = 1'b0;
  endtask

  task automatic clr1();
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"},   32'(bus.rd_valid),   32'd0);
    chk({tag, "_rd_data"},    32'(bus.rd_data),    32'd0);
    chk({tag, "_count"},      32'(bus.fifo_count), 32'd0);
    chk({tag, "_err_parity"}, 32'(bus.err_parity), 32'd0);
    chk({tag, "_err_frame"},  32'(bus.err_frame),  32'd0);
    chk({tag, "_overrun"},    32'(bus.overrun),    32'd0);
    chk({tag, "_state"},      32'(dut.state),      32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Valid 0x1C at 12.5 kHz (40 us half period = 1000 cycles).
    half = 1000;
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    half = 20;
    chk("kb_rd_valid",   32'(bus.rd_valid),   32'd1);
    chk("kb_rd_data",    32'(bus.rd_data),    32'h1C);
    chk("kb_count",      32'(bus.fifo_count), 32'd1);
    chk("kb_err_parity", 32'(bus.err_parity), 32'd0);
    chk("kb_err_frame",  32'(bus.err_frame),  32'd0);
    chk("kb_overrun",    32'(bus.overrun),    32'd0);
    pop1();
    chk("kb_pop_count", 32'(bus.fifo_count), 32'd0);
    chk("kb_pop_valid", 32'(bus.rd_valid),   32'd0);

    // Bad parity.
    send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("par_err",       32'(bus.err_parity), 32'd1);
    chk("par_err_frame", 32'(bus.err_frame),  32'd0);
    chk("par_count",     32'(bus.fifo_count), 32'd0);
    clr1();
    chk("par_clr", 32'(bus.err_parity), 32'd0);

    // Bad stop bit.
    send_frame(8'h55, odd_par(8'h55), 1'b0, -1, 1'b0, 1'b0);
    chk("stop_err_frame",  32'(bus.err_frame),  32'd1);
    chk("stop_err_parity", 32'(bus.err_parity), 32'd0);
    chk("stop_count",      32'(bus.fifo_count), 32'd0);

    // Both checks fail while clr_err is pulsed in the same cycle: set wins.
    send_frame(8'h55, ~odd_par(8'h55), 1'b0, -1, 1'b0, 1'b1);
    chk("both_err_parity", 32'(bus.err_parity), 32'd1);
    chk("both_err_frame",  32'(bus.err_frame),  32'd1);
    clr1();
    chk("both_clr_parity", 32'(bus.err_parity), 32'd0);
    chk("both_clr_frame",  32'(bus.err_frame),  32'd0);

    // Overrun: 17 frames 0x00..0x10, no reads.
    for (int i = 0; i <= 16; i++) good(8'(i));
    chk("ovr_count",   32'(bus.fifo_count), 32'd16);
    chk("ovr_flag",    32'(bus.overrun),    32'd1);
    chk("ovr_rd_data", 32'(bus.rd_data),    32'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_pop%0d", i), 32'(bus.rd_data), 32'(i));
      pop1();
    end
    chk("ovr_empty", 32'(bus.fifo_count), 32'd0);
    clr1();
    chk("ovr_clr", 32'(bus.overrun), 32'd0);

    // Push and pop together while holding one byte.
    good(8'h11);
    send_frame(8'h22, odd_par(8'h22), 1'b1, -1, 1'b1, 1'b0);
    chk("one_pp_count", 32'(bus.fifo_count), 32'd1);
    chk("one_pp_data",  32'(bus.rd_data),    32'h22);
    pop1();

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) good(8'(8'h20 + i));
    send_frame(8'h30, odd_par(8'h30), 1'b1, -1, 1'b1, 1'b0);
    chk("full_pp_count",   32'(bus.fifo_count), 32'd16);
    chk("full_pp_overrun", 32'(bus.overrun),    32'd0);
    chk("full_pp_head",    32'(bus.rd_data),    32'h21);
    repeat (15) pop1();
    chk("full_pp_tail",  32'(bus.rd_data),    32'h30);
    chk("full_pp_last1", 32'(bus.fifo_count), 32'd1);
    pop1();

    // Glitches: low pulse while idle, high pulse inside a bit's low phase.
    @(negedge clk); ps2_clk = 1'b0;
    repeat (3) @(negedge clk); ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_idle_state", 32'(dut.state),      32'(ST_IDLE));
    chk("glitch_idle_count", 32'(bus.fifo_count), 32'd0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 3, 1'b0, 1'b0);
    chk("glitch_count", 32'(bus.fifo_count), 32'd1);
    chk("glitch_data",  32'(bus.rd_data),    32'hF0);
    chk("glitch_flags", 32'({bus.err_parity, bus.err_frame}), 32'd0);
    pop1();

    // Truncated frame: start + 3 data bits, then a 300 us stall.
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7500) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    chk("to_err_frame", 32'(bus.err_frame), 32'd1);
    chk("to_state",     32'(dut.state),     32'(ST_IDLE));
`else
    chk("to_err_frame", 32'(bus.err_frame), 32'd0);
    chk("to_state",     32'(dut.state),     32'(ST_DATA));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif
    good(8'hAA);
    chk("to_next_data",  32'(bus.rd_data),    32'hAA);
    chk("to_next_count", 32'(bus.fifo_count), 32'd1);
    pop1();
    clr1();

    // Reset mid-frame with a byte stored and a flag set.
    good(8'h77);
    send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("mid_pre_count",  32'(bus.fifo_count), 32'd1);
    chk("mid_pre_parity", 32'(bus.err_parity), 32'd1);
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    good(8'h5A);
    chk("mid_next_data",  32'(bus.rd_data),    32'h5A);
    chk("mid_next_count", 32'(bus.fifo_count), 32'd1);
    chk("mid_next_flags", 32'({bus.err_parity, bus.err_frame, bus.overrun}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
